// File: rtl/hack_pkg.sv
// Shared Hack CPU fetch definitions.
// Holds the address/instruction widths and the layout of one fetch-buffer
// entry ({instr, pc}, instruction in the upper bits).
package hack_pkg;

    localparam int HACK_ADDR_W  = 15;
    localparam int HACK_INSTR_W = 16;

    typedef struct packed {
        logic [HACK_INSTR_W-1:0] instr;
        logic [HACK_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic [HACK_INSTR_W-1:0] i_word,
                                                input logic [HACK_ADDR_W-1:0]  i_pc);
        fetch_entry_t e;
        e.instr = i_word;
        e.pc    = i_pc;
        return e;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: program_counter controls, instruction ROM port, jump
// redirect from execute and the valid/ready instruction output.
//   master : the fetch stage (drives pc controls, rom_addr, instr*)
//   slave  : the surrounding pipeline (drives pc, rom_data, jmp*, instr_ready)
interface instruction_fetch_if;
    import hack_pkg::*;

    logic [HACK_ADDR_W-1:0]  pc;
    logic                    pc_inc;
    logic                    pc_load;
    logic [HACK_ADDR_W-1:0]  pc_load_val;
    logic [HACK_ADDR_W-1:0]  rom_addr;
    logic [HACK_INSTR_W-1:0] rom_data;
    logic                    jmp_req;
    logic [HACK_ADDR_W-1:0]  jmp_addr;
    logic [HACK_INSTR_W-1:0] instr;
    logic [HACK_ADDR_W-1:0]  instr_pc;
    logic                    instr_valid;
    logic                    instr_ready;

    modport master (
        input  pc, rom_data, jmp_req, jmp_addr, instr_ready,
        output pc_inc, pc_load, pc_load_val, rom_addr, instr, instr_pc, instr_valid
    );

    modport slave (
        output pc, rom_data, jmp_req, jmp_addr, instr_ready,
        input  pc_inc, pc_load, pc_load_val, rom_addr, instr, instr_pc, instr_valid
    );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO holding fetched {instr, pc} entries.
// Ports: clk, rst_n (async, active-low, clears count only),
//        push_i/data_i write, pop_i read, flush_i empties the buffer,
//        head_o/valid_o oldest entry, count_o occupancy 0..2.
// Entry 0 is always the head; a pop shifts entry 1 down.
module fetch_buffer #(
    parameter int W = 31
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] head_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] ent0_q, ent1_q;
    logic [1:0]   count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else if (push_i && !pop_i) begin
            count_d = count_q + 2'd1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Data storage needs no reset: count decides what is visible.
    always_ff @(posedge clk) begin
        if (pop_i && count_q == 2'd2) begin
            ent0_q <= ent1_q;
        end else if (push_i && (count_q == 2'd0 || (pop_i && count_q == 2'd1))) begin
            ent0_q <= data_i;
        end
        if (push_i && ((count_q == 2'd1 && !pop_i) || (count_q == 2'd2 && pop_i))) begin
            ent1_q <= data_i;
        end
    end

    assign head_o  = ent0_q;
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Hack fetch stage between program_counter and decode/execute.
// Ports: clk, rst_n (async, active-low), bus (instruction_fetch_if.master):
//   pc in / pc_inc, pc_load, pc_load_val out to program_counter,
//   rom_addr out / rom_data in (1-cycle synchronous ROM),
//   jmp_req, jmp_addr redirect in, instr, instr_pc, instr_valid out,
//   instr_ready in.
// One ROM read may be in flight; it is only issued when the buffer is
// guaranteed to have room for it on return.
module instruction_fetch
    import hack_pkg::*;
#(
    parameter int ADDR_W  = HACK_ADDR_W,
    parameter int INSTR_W = HACK_INSTR_W,
    parameter int DEPTH   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master bus
);

    localparam int ENTRY_W = $bits(fetch_entry_t);

    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               buf_push, buf_pop, buf_valid;
    logic [1:0]         buf_count;
    logic [ENTRY_W-1:0] buf_head;
    fetch_entry_t       push_entry, head_entry;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;
    logic [2:0]         occupancy;
    logic               issue;

    always_comb begin
        buf_pop       = buf_valid & bus.instr_ready;
        // Entries that will be held after this edge plus the read in flight.
        occupancy     = {1'b0, buf_count} - {2'b00, buf_pop} + {2'b00, inflight_q};
        issue         = rst_n & ~bus.jmp_req & (int'(occupancy) < DEPTH);
        // Data returning during a jump cycle is wrong-path and dropped.
        buf_push      = inflight_q & ~bus.jmp_req;
        inflight_d    = issue;
        inflight_pc_d = issue ? bus.pc : inflight_pc_q;
        push_entry    = make_entry(bus.rom_data, inflight_pc_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_buffer #(.W(ENTRY_W)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .flush_i (bus.jmp_req),
        .data_i  (push_entry),
        .head_o  (buf_head),
        .valid_o (buf_valid),
        .count_o (buf_count)
    );

    assign head_entry = fetch_entry_t'(buf_head);
    assign head_instr = head_entry.instr;
    assign head_pc    = head_entry.pc;

    // Outputs are forced quiet while reset is held, independent of the clock.
    assign bus.rom_addr    = bus.pc;
    assign bus.pc_inc      = issue;
    assign bus.pc_load     = rst_n & bus.jmp_req;
    assign bus.pc_load_val = rst_n ? bus.jmp_addr : '0;
    assign bus.instr_valid = rst_n & buf_valid;
    assign bus.instr       = rst_n ? head_instr : '0;
    assign bus.instr_pc    = rst_n ? head_pc : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        pc_force;
    logic [14:0] pc_force_val;
    logic [14:0] pc_m;
    logic [15:0] rom [0:32767];
    logic [15:0] rom_q;
    logic [30:0] sb_q[$];
    int          pass_cnt;
    int          total_cnt;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // program_counter model
    always @(posedge clk) begin
        if (pc_force)          pc_m <= pc_force_val;
        else if (bus.pc_load)  pc_m <= bus.pc_load_val;
        else if (bus.pc_inc)   pc_m <= pc_m + 15'd1;
    end

    // synchronous instruction ROM model
    always @(posedge clk) rom_q <= rom[bus.rom_addr];

    assign bus.pc       = pc_m;
    assign bus.rom_data = rom_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic exp_push(input logic [14:0] a);
        sb_q.push_back({rom[a], a});
    endtask

    // Checks any handshake of the current cycle against the scoreboard,
    // then advances to the next falling edge.
    task automatic step();
        logic [30:0] e;
        #2;
        if (rst_n && bus.instr_valid && bus.instr_ready) begin
            total_cnt++;
            assert (sb_q.size() > 0) pass_cnt++;
            else $error("FAIL sb_unexpected: observed pc %0h expected no delivery", bus.instr_pc);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_instr", 32'(bus.instr), 32'(e[30:15]));
                chk("sb_pc", 32'(bus.instr_pc), 32'(e[14:0]));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        pass_cnt         = 0;
        total_cnt        = 0;
        rst_n            = 1'b0;
        pc_force         = 1'b1;
        pc_force_val     = 15'd0;
        bus.jmp_req      = 1'b0;
        bus.jmp_addr     = 15'd0;
        bus.instr_ready  = 1'b1;
        for (int i = 0; i < 32768; i++) rom[i] = 16'(i * 40503 + 12345);
        rom[0] = 16'h0005;
        rom[1] = 16'hEC10;
        rom[2] = 16'h0007;
        rom[3] = 16'hE308;
        @(negedge clk);

        // reset state, with a jump request that must be ignored
        bus.jmp_req  = 1'b1;
        bus.jmp_addr = 15'h1234;
        #1;
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_pc_inc", 32'(bus.pc_inc), 32'd0);
        chk("rst_pc_load", 32'(bus.pc_load), 32'd0);
        chk("rst_load_val", 32'(bus.pc_load_val), 32'd0);
        chk("rst_instr", 32'(bus.instr), 32'd0);
        chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
        bus.jmp_req  = 1'b0;
        bus.jmp_addr = 15'd0;
        step();

        // streaming from pc 0
        pc_force = 1'b0;
        rst_n    = 1'b1;
        for (int a = 0; a < 4; a++) exp_push(15'(a));
        #1;
        chk("s1_pc_inc", 32'(bus.pc_inc), 32'd1);
        chk("s1_rom_addr", 32'(bus.rom_addr), 32'd0);
        step();
        chk("s1_lat1_valid", 32'(bus.instr_valid), 32'd0);
        step();
        chk("s1_lat2_valid", 32'(bus.instr_valid), 32'd1);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("s1_rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("s1_drain", 32'(sb_q.size()), 32'd0);

        // stall with backpressure
        pc_force     = 1'b1;
        pc_force_val = 15'd0;
        step();
        pc_force = 1'b0;
        rst_n    = 1'b1;
        exp_push(15'd0);
        exp_push(15'd1);
        step();
        step();
        bus.instr_ready = 1'b0;
        #1;
        chk("stall_valid", 32'(bus.instr_valid), 32'd1);
        chk("stall_pc_inc", 32'(bus.pc_inc), 32'd0);
        step();
        chk("full_pc_inc", 32'(bus.pc_inc), 32'd0);
        chk("full_pc", 32'(pc_m), 32'd2);
        chk("full_instr", 32'(bus.instr), 32'h0005);
        chk("full_instr_pc", 32'(bus.instr_pc), 32'd0);
        step();
        chk("hold_instr", 32'(bus.instr), 32'h0005);
        chk("hold_valid", 32'(bus.instr_valid), 32'd1);
        chk("hold_pc", 32'(pc_m), 32'd2);
        bus.instr_ready = 1'b1;
        #1;
        chk("resume_pc_inc", 32'(bus.pc_inc), 32'd1);
        step();
        chk("nogap_valid", 32'(bus.instr_valid), 32'd1);
        chk("nogap_instr", 32'(bus.instr), 32'hEC10);
        chk("nogap_pc", 32'(bus.instr_pc), 32'd1);
        step();
        bus.instr_ready = 1'b0;
        step();
        chk("full2_pc_inc", 32'(bus.pc_inc), 32'd0);
        chk("full2_valid", 32'(bus.instr_valid), 32'd1);
        bus.jmp_req  = 1'b1;
        bus.jmp_addr = 15'h0040;
        #1;
        chk("pre_rst_load", 32'(bus.pc_load), 32'd1);
        // asynchronous reset between edges with the buffer full
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.instr_valid), 32'd0);
        chk("arst_pc_inc", 32'(bus.pc_inc), 32'd0);
        chk("arst_pc_load", 32'(bus.pc_load), 32'd0);
        chk("s2_drain", 32'(sb_q.size()), 32'd0);
        bus.jmp_req  = 1'b0;
        bus.jmp_addr = 15'd0;
        step();
        chk("arst_pc_hold", 32'(pc_m), 32'd4);

        // restart from current pc, then jump while in flight with count 1
        bus.instr_ready = 1'b1;
        rst_n           = 1'b1;
        exp_push(15'd4);
        #1;
        chk("restart_pc_inc", 32'(bus.pc_inc), 32'd1);
        chk("restart_addr", 32'(bus.rom_addr), 32'd4);
        step();
        step();
        bus.jmp_req  = 1'b1;
        bus.jmp_addr = 15'h0010;
        exp_push(15'h0010);
        #1;
        chk("jmp_pc_load", 32'(bus.pc_load), 32'd1);
        chk("jmp_load_val", 32'(bus.pc_load_val), 32'h0010);
        chk("jmp_pc_inc", 32'(bus.pc_inc), 32'd0);
        chk("jmp_head_valid", 32'(bus.instr_valid), 32'd1);
        step();
        bus.jmp_req = 1'b0;
        #1;
        chk("jmp_flush_valid", 32'(bus.instr_valid), 32'd0);
        step();
        chk("jmp_wait_valid", 32'(bus.instr_valid), 32'd0);
        step();
        chk("jmp_lat_valid", 32'(bus.instr_valid), 32'd1);
        chk("jmp_lat_pc", 32'(bus.instr_pc), 32'h0010);

        // back-to-back jumps
        bus.jmp_req  = 1'b1;
        bus.jmp_addr = 15'h0020;
        step();
        bus.jmp_addr = 15'h0030;
        #1;
        chk("b2b_load_val", 32'(bus.pc_load_val), 32'h0030);
        chk("b2b_valid", 32'(bus.instr_valid), 32'd0);
        step();
        bus.jmp_req = 1'b0;
        for (int a = 'h30; a < 'h34; a++) exp_push(15'(a));
        #1;
        chk("b2b_flush1", 32'(bus.instr_valid), 32'd0);
        step();
        chk("b2b_flush2", 32'(bus.instr_valid), 32'd0);
        step();
        chk("b2b_first_pc", 32'(bus.instr_pc), 32'h0030);
        repeat (3) step();

        // pc wrap
        bus.jmp_req  = 1'b1;
        bus.jmp_addr = 15'h7FFE;
        step();
        bus.jmp_req = 1'b0;
        exp_push(15'h7FFE);
        exp_push(15'h7FFF);
        exp_push(15'h0000);
        exp_push(15'h0001);
        step();
        step();
        chk("wrap_first_pc", 32'(bus.instr_pc), 32'h7FFE);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("final_drain", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage sitting directly downstream of program_counter.
- Drives the counter's inc/load controls and uses its 15-bit output as the instruction ROM address (synchronous ROM, 1-cycle read latency).
- Buffers fetched 16-bit Hack instructions in a 2-entry queue and hands them to the decode/execute stage over a valid/ready handshake.
- Accepts jump redirects from execute and flushes wrong-path instructions.

Parameters:
ADDR_W, 15, instruction address width (matches program_counter)
INSTR_W, 16, instruction word width
DEPTH, 2, output buffer entries (fixed at 2; other values unsupported)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
pc  input  ADDR_W  current program_counter output
pc_inc  output  1  to program_counter inc
pc_load  output  1  to program_counter load
pc_load_val  output  ADDR_W  to program_counter in
rom_addr  output  ADDR_W  instruction ROM address
rom_data  input  INSTR_W  ROM read data, valid one cycle after rom_addr
jmp_req  input  1  redirect request from execute (single-cycle pulse)
jmp_addr  input  ADDR_W  redirect target
instr  output  INSTR_W  buffer head instruction
instr_pc  output  ADDR_W  address of instr
instr_valid  output  1  buffer head valid
instr_ready  input  1  consumer accepts head this cycle

Behaviour:
- State: inflight flag, inflight_pc register, 2-entry buffer with count 0..2.
- Reset (rst_n low, asynchronous): count=0, inflight=0, inflight_pc=0.
  - While rst_n is low: instr_valid=0, pc_inc=0, pc_load=0, pc_load_val=0, instr=0, instr_pc=0.
- rom_addr = pc, combinational.
- pop = instr_valid & instr_ready.
- Issue condition: rst_n & !jmp_req & ((count - pop + inflight) < 2).
- On issue:
  - pc_inc=1 in the same cycle.
  - Next edge: inflight<=1, inflight_pc<=pc.
  - Otherwise next edge: inflight<=0.
- Capture: if inflight & !jmp_req at the edge, push {rom_data, inflight_pc} into the buffer.
  - The issue rule guarantees the buffer is never full when a push occurs.
- Push and pop in the same cycle: count is unchanged and order is preserved.
- Throughput: 1 instruction/cycle sustained with instr_ready=1. First instr_valid appears 2 cycles after the first issue cycle.
- Backpressure: with instr_ready=0, the buffer fills to 2 and issue stops. instr, instr_pc and instr_valid hold stable until accepted.
- Jump (jmp_req=1):
  - Same cycle: pc_load=1, pc_load_val=jmp_addr, pc_inc=0, no issue.
  - Next edge: count<=0, inflight<=0. The ROM data arriving that cycle is discarded.
  - A pop occurring in the jump cycle is still a legal handshake; the consumer owns it.
  - First instruction from jmp_addr is valid 3 cycles after the jump cycle: issue at +1, capture at +2, visible at +2 post-edge.
- Back-to-back jumps: each one reloads the PC and flushes; the last one wins.
- pc wrap: pc=0x7FFF followed by inc gives 0 (program_counter behaviour); the fetch stage needs no special handling.
- instr_pc is carried through exactly; no arithmetic is performed in this block.
- Reset mid-stream: everything clears immediately. Fetch resumes from whatever pc presents after rst_n rises.

Decomposition:
- hack_pkg:
  - HACK_ADDR_W=15, HACK_INSTR_W=16
  - fetch entry struct/concatenation layout {instr, pc}
- Sub-module fetch_buffer: 2-entry synchronous FIFO.
  - Inputs: push, pop, flush, data.
  - Outputs: head, valid, count.
  - Asynchronous active-low reset.
- instruction_fetch: issue/inflight control and jump flush.

Test Plan:
- Reset release with pc=0, ROM[0..3]=0005,EC10,0007,E308, instr_ready=1:
  - pc_inc=1 from the first cycle.
  - instr_valid rises 2 cycles later with (0005, pc 0), then EC10/1, 0007/2, E308/3 on consecutive cycles.
- Stall: instr_ready=0 after the first fetch:
  - count reaches 2, pc_inc drops to 0, pc holds at 2.
  - instr stays 0005/0 until ready=1; then EC10/1 follows next cycle with no gap or duplicate.
- Jump: jmp_req with jmp_addr=0x0010 while inflight and count=1:
  - pc_load=1, pc_load_val=0010, pc_inc=0.
  - instr_valid=0 next cycle; ROM[0x10] appears with instr_pc=0x0010 3 cycles after the jump; no wrong-path instruction ever appears.
- Back-to-back jumps to 0x0020 then 0x0030 in consecutive cycles: only instructions from 0x0030 onward are delivered.
- Wrap: pc=0x7FFE streaming: instr_pc sequence 7FFE, 7FFF, 0000, 0001.
- Asynchronous reset asserted mid-stream with count=2, between clock edges:
  - instr_valid, pc_inc and pc_load go to 0 immediately.
  - After release, fetch restarts cleanly from the current pc.
